// File: rtl/band_mix_accum.sv
// rtl/band_mix_accum.sv - per-band gain mixer with time-shared MAC and 16-bit saturation
//
// Purpose: gathers one signed sample per band per frame, multiplies each enabled
// band by its unsigned gain (GAIN_FRAC fractional bits) through one shared
// multiplier, sums, shifts the fraction out, clamps to DATA_W and strobes out.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   band_data     packed signed samples, band i at [i*DATA_W +: DATA_W]
//   band_valid    per-band one-cycle sample strobe
//   band_en       per-band participation mask
//   band_gain     packed unsigned gains, band i at [i*GAIN_W +: GAIN_W]
//   clip_clr      (BAND_MIX_CLIP_FLAG_EN only) synchronous clear of clip_sticky
//   clip_sticky   (BAND_MIX_CLIP_FLAG_EN only) set whenever the clamp altered a result
//   mix_out       registered saturated mix
//   mix_valid     one-cycle strobe, mix_out updated
//
// Optional feature macro: BAND_MIX_CLIP_FLAG_EN
`timescale 1ns/1ps

module band_mix_accum #(
  parameter int NUM_BANDS = 4,
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_BANDS*DATA_W-1:0]   band_data,
  input  logic [NUM_BANDS-1:0]          band_valid,
  input  logic [NUM_BANDS-1:0]          band_en,
  input  logic [NUM_BANDS*GAIN_W-1:0]   band_gain,
`ifdef BAND_MIX_CLIP_FLAG_EN
  input  logic                          clip_clr,
  output logic                          clip_sticky,
`endif
  output logic [DATA_W-1:0]             mix_out,
  output logic                          mix_valid
);

  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam int ACC_W  = PROD_W + $clog2(NUM_BANDS);
  localparam int IDX_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DATA_W-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_SAT} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [DATA_W-1:0]         r_cap   [NUM_BANDS];
  logic [DATA_W-1:0]         r_work  [NUM_BANDS];
  logic [GAIN_W-1:0]         r_gain_snap [NUM_BANDS];
  logic [NUM_BANDS-1:0]      r_pend;
  logic [NUM_BANDS-1:0]      w_pend_nxt;
  logic signed [ACC_W-1:0]   r_acc;
  logic [IDX_W-1:0]          r_idx;
  logic [DATA_W-1:0]         r_mix_out;
  logic                      r_mix_valid;

  logic                      w_frame_done;
  logic                      w_last;
  logic signed [DATA_W-1:0]  w_sample;
  logic signed [GAIN_W:0]    w_gain_s;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_shift;
  logic                      w_hi;
  logic                      w_lo;
  logic [DATA_W-1:0]         w_sat;

  // Every enabled band has delivered, and at least one band is enabled.
  assign w_frame_done = (&(r_pend | ~band_en)) && (|(r_pend & band_en));
  assign w_last       = (r_idx == IDX_W'(NUM_BANDS - 1));

  // Gain is zero-extended by one bit so the multiply stays signed.
  assign w_sample = r_work[r_idx];
  assign w_gain_s = {1'b0, r_gain_snap[r_idx]};
  assign w_prod   = PROD_W'(w_sample) * PROD_W'(w_gain_s);

  assign w_shift = r_acc >>> GAIN_FRAC;
  assign w_hi    = (w_shift > SAT_MAX);
  assign w_lo    = (w_shift < SAT_MIN);
  assign w_sat   = w_hi ? SAT_MAX[DATA_W-1:0] :
                   w_lo ? SAT_MIN[DATA_W-1:0] : w_shift[DATA_W-1:0];

  // Consumed pend bits clear on frame launch, but a strobe on the same edge wins.
  always_comb begin
    w_pend_nxt = r_pend;
    if (r_state == S_IDLE && w_frame_done)
      w_pend_nxt = '0;
    w_pend_nxt = w_pend_nxt | band_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      for (int i = 0; i < NUM_BANDS; i++) r_cap[i] <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      for (int i = 0; i < NUM_BANDS; i++)
        if (band_valid[i]) r_cap[i] <= band_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_frame_done) w_state_nxt = S_MAC;
      S_MAC:   if (w_last)       w_state_nxt = S_SAT;
      S_SAT:                     w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_idx       <= '0;
      r_mix_out   <= '0;
      r_mix_valid <= 1'b0;
      for (int i = 0; i < NUM_BANDS; i++) begin
        r_work[i]      <= '0;
        r_gain_snap[i] <= '0;
      end
    end else begin
      r_mix_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_frame_done) begin
            r_work <= r_cap;
            for (int i = 0; i < NUM_BANDS; i++)
              r_gain_snap[i] <= band_gain[i*GAIN_W +: GAIN_W];
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        S_MAC: begin
          // Enable is sampled live; a band disabled now contributes nothing.
          if (band_en[r_idx]) r_acc <= r_acc + ACC_W'(w_prod);
          r_idx <= r_idx + IDX_W'(1);
        end
        S_SAT: begin
          r_mix_out   <= w_sat;
          r_mix_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mix_out   = r_mix_out;
  assign mix_valid = r_mix_valid;

`ifdef BAND_MIX_CLIP_FLAG_EN
  logic r_clip_sticky;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_clip_sticky <= 1'b0;
    else if (r_state == S_SAT && (w_hi || w_lo)) r_clip_sticky <= 1'b1;
    else if (clip_clr)                         r_clip_sticky <= 1'b0;
  end

  assign clip_sticky = r_clip_sticky;
`endif

endmodule

// File: tb/tb_band_mix_accum.sv
// tb/tb_band_mix_accum.sv - scoreboard bench for band_mix_accum
`timescale 1ns/1ps

module tb_band_mix_accum;
  localparam int NB = 4;
  localparam int DW = 16;
  localparam int GW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NB*DW-1:0] band_data;
  logic [NB-1:0]    band_valid;
  logic [NB-1:0]    band_en;
  logic [NB*GW-1:0] band_gain;
  logic [DW-1:0]    mix_out;
  logic             mix_valid;
`ifdef BAND_MIX_CLIP_FLAG_EN
  logic             clip_clr;
  logic             clip_sticky;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pulses = 0;

  typedef struct {
    logic signed [DW-1:0] val;
    int                   at;
  } exp_t;
  exp_t sb[$];

  band_mix_accum dut (
    .clk        (clk),
    .rst        (rst),
    .band_data  (band_data),
    .band_valid (band_valid),
    .band_en    (band_en),
    .band_gain  (band_gain),
`ifdef BAND_MIX_CLIP_FLAG_EN
    .clip_clr   (clip_clr),
    .clip_sticky(clip_sticky),
`endif
    .mix_out    (mix_out),
    .mix_valid  (mix_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    if (mix_valid) begin
      exp_t e;
      pulses++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pulse: got mix_out=%0d at cycle %0d, expected no pulse", $signed(mix_out), cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checks++;
        assert (mix_out === e.val) else begin
          errors++;
          $error("FAIL mix_value: got %0d, expected %0d", $signed(mix_out), e.val);
        end
        if (e.at >= 0) begin
          checks++;
          assert (cyc === e.at) else begin
            errors++;
            $error("FAIL mix_latency: pulse at cycle %0d, expected cycle %0d", cyc, e.at);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [NB-1:0] v, input logic signed [DW-1:0] d0, d1, d2, d3, output int t);
    @(negedge clk);
    band_data  = {d3, d2, d1, d0};
    band_valid = v;
    t = cyc;
    @(negedge clk);
    band_valid = '0;
  endtask

  task automatic expect_mix(input logic signed [DW-1:0] v, input int at);
    exp_t e;
    e.val = v;
    e.at  = at;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL %s_timeout: %0d results outstanding, expected 0", tag, sb.size());
    end
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

`ifdef BAND_MIX_CLIP_FLAG_EN
  task automatic check_clip(input logic exp_v, input string tag);
    checks++;
    assert (clip_sticky === exp_v) else begin
      errors++;
      $error("FAIL %s: clip_sticky=%b, expected %b", tag, clip_sticky, exp_v);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clip_clr = 1'b1;
    @(negedge clk);
    clip_clr = 1'b0;
  endtask
`endif

  initial begin
    int t, t2, p0;
    rst        = 1'b1;
    band_data  = '0;
    band_valid = '0;
    band_en    = '0;
    band_gain  = '0;
`ifdef BAND_MIX_CLIP_FLAG_EN
    clip_clr   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    assert (mix_out === 16'd0) else begin
      errors++; $error("FAIL reset_mix_out: got %0d, expected 0", $signed(mix_out));
    end
    checks++;
    assert (mix_valid === 1'b0) else begin
      errors++; $error("FAIL reset_mix_valid: got %b, expected 0", mix_valid);
    end
`ifdef BAND_MIX_CLIP_FLAG_EN
    check_clip(1'b0, "reset_clip");
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Unity gain, all bands on the same cycle.
    band_en   = 4'b1111;
    band_gain = {4{8'd64}};
    send(4'b1111, 16'sd100, 16'sd200, -16'sd50, 16'sd10, t);
    expect_mix(16'sd260, t + 7);
    drain("unity");
`ifdef BAND_MIX_CLIP_FLAG_EN
    check_clip(1'b0, "unity_no_clip");
`endif

    // Positive and negative saturation.
    band_gain = {4{8'd255}};
    send(4'b1111, 16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, t);
    expect_mix(16'sd32767, t + 7);
    drain("sat_pos");
`ifdef BAND_MIX_CLIP_FLAG_EN
    check_clip(1'b1, "sat_pos_clip");
    pulse_clr();
    check_clip(1'b0, "sat_pos_clr");
`endif
    send(4'b1111, -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, t);
    expect_mix(-16'sd32768, t + 7);
    drain("sat_neg");
`ifdef BAND_MIX_CLIP_FLAG_EN
    check_clip(1'b1, "sat_neg_clip");
    pulse_clr();
    check_clip(1'b0, "sat_neg_clr");
`endif

    // Staggered arrival with bands 1 and 3 masked.
    band_en   = 4'b0101;
    band_gain = {4{8'd128}};
    send(4'b0001, 16'sd1000, 16'sd9999, -16'sd300, 16'sd9999, t);
    repeat (8) @(negedge clk);
    send(4'b0100, 16'sd1000, 16'sd9999, -16'sd300, 16'sd9999, t2);
    expect_mix(16'sd1400, t2 + 7);
    drain("stagger");

    // Only masked bands deliver: no frame may complete.
    p0 = pulses;
    send(4'b1010, 16'sd0, 16'sd5, 16'sd0, 16'sd7, t);
    repeat (20) @(negedge clk);
    checks++;
    assert (pulses === p0) else begin
      errors++; $error("FAIL masked_only: %0d pulses, expected 0", pulses - p0);
    end

    // Truncation toward minus infinity with a single enabled band.
    band_en   = 4'b0001;
    band_gain = {4{8'd32}};
    send(4'b0001, -16'sd1, 16'sd0, 16'sd0, 16'sd0, t);
    expect_mix(-16'sd1, t + 7);
    drain("trunc_neg");
    send(4'b0001, 16'sd1, 16'sd0, 16'sd0, 16'sd0, t);
    expect_mix(16'sd0, t + 7);
    drain("trunc_pos");

    // Back-to-back: next frame and a gain change arrive while the first is in MAC.
    band_en   = 4'b1111;
    band_gain = {4{8'd128}};
    send(4'b1111, 16'sd100, 16'sd200, -16'sd50, 16'sd10, t);
    expect_mix(16'sd520, t + 7);
    @(negedge clk);
    band_gain = {4{8'd64}};
    send(4'b1111, 16'sd1, 16'sd1, 16'sd1, 16'sd1, t2);
    expect_mix(16'sd4, -1);
    drain("back2back");

    // Reset in the middle of MAC discards the frame.
    p0 = pulses;
    send(4'b1111, 16'sd1000, 16'sd1000, 16'sd1000, 16'sd1000, t);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    assert (mix_out === 16'd0) else begin
      errors++; $error("FAIL midmac_rst_out: got %0d, expected 0", $signed(mix_out));
    end
    checks++;
    assert (mix_valid === 1'b0) else begin
      errors++; $error("FAIL midmac_rst_valid: got %b, expected 0", mix_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    assert (pulses === p0) else begin
      errors++; $error("FAIL midmac_aborted: %0d pulses, expected 0", pulses - p0);
    end
    send(4'b1111, 16'sd100, 16'sd200, -16'sd50, 16'sd10, t);
    expect_mix(16'sd260, t + 7);
    drain("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
